// File: rtl/psram_spi_responder.sv
// psram_spi_responder: device end of the SPI-mode PSRAM link.
// Decodes READ (0x03), FAST READ (0x0B) and WRITE (0x02) against an internal
// byte array. Every SPI pin is oversampled on clk; nothing is clocked by sclk.
module psram_spi_responder #(
  parameter int MEM_AW    = 10,
  parameter int DUMMY_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_n,
  input  logic       sclk,
  input  logic       si,
  output logic       so,
  output logic       so_oe,
  output logic       busy,
  output logic       bad_cmd,
  output logic [2:0] dbg_state_o
);

  localparam int MEM_DEPTH = 1 << MEM_AW;
  // Shift register only needs to hold what the opcode and the used address bits need.
  localparam int SH_W = (MEM_AW > 8) ? MEM_AW - 1 : 7;
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_IGNORE = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic ce_m_q, ce_s_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic si_m_q, si_s_q;

  logic [SH_W-1:0]   sh_q;
  logic [4:0]        bit_cnt_q;
  logic [7:0]        opcode_q;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        tx_q;
  logic              so_q;
  logic              bad_q;
  logic              mem_ld_q;

  logic [7:0] mem_q [0:MEM_DEPTH-1];

  logic       rise, fall;
  logic [7:0] cmd_byte;
  logic       cmd_ok;
  logic       mem_we;

  // sclk edges are ignored on any clk where the synchronized ce_n is high,
  // so a ce_n rise always wins over a coincident edge.
  assign rise     = sclk_s_q & ~sclk_p_q & ~ce_s_q;
  assign fall     = ~sclk_s_q & sclk_p_q & ~ce_s_q;
  assign cmd_byte = {sh_q[6:0], si_s_q};
  assign cmd_ok   = (cmd_byte == 8'h03) || (cmd_byte == 8'h0B) || (cmd_byte == 8'h02);
  assign mem_we   = (state_q == ST_WRITE) && rise && (bit_cnt_q == 5'd7);

  // Two-flop synchronizers for every SPI input, plus one extra sclk stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_m_q   <= 1'b1;
      ce_s_q   <= 1'b1;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      si_m_q   <= 1'b0;
      si_s_q   <= 1'b0;
    end else begin
      ce_m_q   <= ce_n;
      ce_s_q   <= ce_m_q;
      sclk_m_q <= sclk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      si_m_q   <= si;
      si_s_q   <= si_m_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: ce_n high returns to IDLE from anywhere; otherwise advance on sclk rises.
  always_comb begin
    state_d = state_q;
    if (ce_s_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (rise && (bit_cnt_q == 5'd7)) state_d = cmd_ok ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: begin
          if (rise && (bit_cnt_q == 5'd23)) begin
            if (opcode_q == 8'h0B)      state_d = ST_DUMMY;
            else if (opcode_q == 8'h03) state_d = ST_READ;
            else                        state_d = ST_WRITE;
          end
        end
        ST_DUMMY: begin
          if (rise && (bit_cnt_q == DUMMY_LAST)) state_d = ST_READ;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: so is only driven during the read data phase.
  always_comb begin
    so          = so_q;
    so_oe       = (state_q == ST_READ);
    busy        = (state_q != ST_IDLE);
    bad_cmd     = bad_q;
    dbg_state_o = state_q;
  end

  // Datapath: shifting, bit counting, address tracking and the read prefetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
      opcode_q  <= '0;
      addr_q    <= '0;
      tx_q      <= '0;
      so_q      <= 1'b0;
      bad_q     <= 1'b0;
      mem_ld_q  <= 1'b0;
    end else begin
      bad_q    <= 1'b0;
      mem_ld_q <= 1'b0;
      // Prefetch lands one clk after it is requested, well before the next sclk fall.
      if (mem_ld_q) tx_q <= mem_q[addr_q];
      if (state_d == ST_IDLE) begin
        bit_cnt_q <= '0;
        so_q      <= 1'b0;
        mem_ld_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: bit_cnt_q <= '0;
          ST_CMD: begin
            if (rise) begin
              sh_q <= {sh_q[SH_W-2:0], si_s_q};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                opcode_q  <= cmd_byte;
                bad_q     <= ~cmd_ok;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              sh_q <= {sh_q[SH_W-2:0], si_s_q};
              if (bit_cnt_q == 5'd23) begin
                bit_cnt_q <= '0;
                // Upper address bits have already shifted out: they alias.
                addr_q    <= {sh_q[MEM_AW-2:0], si_s_q};
                mem_ld_q  <= (opcode_q == 8'h03);
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (rise) begin
              if (bit_cnt_q == DUMMY_LAST) begin
                bit_cnt_q <= '0;
                mem_ld_q  <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_READ: begin
            if (fall) begin
              so_q <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                addr_q    <= addr_q + 1'b1;
                mem_ld_q  <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          ST_WRITE: begin
            if (rise) begin
              sh_q <= {sh_q[SH_W-2:0], si_s_q};
              if (bit_cnt_q == 5'd7) begin
                bit_cnt_q <= '0;
                addr_q    <= addr_q + 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          default: bit_cnt_q <= bit_cnt_q;
        endcase
      end
    end
  end

  // Byte array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= cmd_byte;
  end

endmodule
